// File: rtl/mod_step_counter.sv
// mod_step_counter: parametrised up/down counter with load, programmable step,
// programmable modulo limit, wrap/saturate mode and boundary status flags.
// The count and both event pulses are registered. at_zero and at_limit
// follow count and limit combinationally.

module mod_step_counter #(
    parameter int              WIDTH     = 8,
    parameter int              STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              enable,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count,
    output logic              wrap_pulse,
    output logic              sat_pulse,
    output logic              at_zero,
    output logic              at_limit
);

    // One extra bit so that count + step and count + limit + 1 never overflow.
    localparam int            EW    = WIDTH + 1;
    localparam logic [EW-1:0] ONE_X = EW'(1);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             sat_q;

    logic [EW-1:0]    cnt_x;
    logic [EW-1:0]    lim_x;
    logic [EW-1:0]    step_x;
    logic [EW-1:0]    es_x;
    logic [EW-1:0]    up_sum;
    logic             out_of_range;
    logic             up_over;
    logic             dn_under;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] up_wrap_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] dn_wrap_val;

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             sat_d;

    // Widen operands, clamp the step to the limit and precompute every candidate result.
    always_comb begin
        cnt_x        = {1'b0, count_q};
        lim_x        = {1'b0, limit};
        step_x       = EW'(step);
        es_x         = (step_x > lim_x) ? lim_x : step_x;
        up_sum       = cnt_x + es_x;
        out_of_range = (cnt_x > lim_x);
        up_over      = (up_sum > lim_x);
        dn_under     = (es_x > cnt_x);
        // Every candidate below is <= limit when selected, so narrowing is lossless.
        up_val       = WIDTH'(up_sum);
        up_wrap_val  = WIDTH'(up_sum - lim_x - ONE_X);
        dn_val       = WIDTH'(cnt_x - es_x);
        dn_wrap_val  = WIDTH'(cnt_x + lim_x + ONE_X - es_x);
        load_val     = (data_in > limit) ? limit : data_in;
    end

    // Select next count and pulse values: load beats enable, enable beats hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            if (out_of_range) begin
                // Limit was lowered below the count; recover to a boundary.
                if (sat_mode) begin
                    count_d = limit;
                    sat_d   = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else if (up_dn) begin
                if (!up_over) begin
                    count_d = up_val;
                end else if (sat_mode) begin
                    count_d = limit;
                    sat_d   = 1'b1;
                end else begin
                    count_d = up_wrap_val;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!dn_under) begin
                    count_d = dn_val;
                end else if (sat_mode) begin
                    count_d = '0;
                    sat_d   = 1'b1;
                end else begin
                    count_d = dn_wrap_val;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // Register count and pulses; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign sat_pulse  = sat_q;
    assign at_zero    = (count_q == '0);
    assign at_limit   = (count_q == limit);

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.

module tb_mod_step_counter;

    localparam int RST_VAL = 0;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic       enable;
    logic       up_dn;
    logic [3:0] step;
    logic [7:0] limit;
    logic       sat_mode;
    logic [7:0] count;
    logic       wrap_pulse;
    logic       sat_pulse;
    logic       at_zero;
    logic       at_limit;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    bit m_wrap  = 0;
    bit m_sat   = 0;
    bit m_valid = 0;

    mod_step_counter #(
        .WIDTH(8),
        .STEP_W(4),
        .RESET_VAL(8'(RST_VAL))
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data_in(data_in),
        .enable(enable),
        .up_dn(up_dn),
        .step(step),
        .limit(limit),
        .sat_mode(sat_mode),
        .count(count),
        .wrap_pulse(wrap_pulse),
        .sat_pulse(sat_pulse),
        .at_zero(at_zero),
        .at_limit(at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: apply the counting rules with plain integer arithmetic.
    always @(posedge clk) begin
        int c, lim, es, d;
        bit w, s;
        c   = m_count;
        lim = int'(limit);
        d   = int'(data_in);
        w   = 0;
        s   = 0;
        if (rst) begin
            c = RST_VAL;
        end else if (load) begin
            c = (d < lim) ? d : lim;
        end else if (enable) begin
            es = (int'(step) < lim) ? int'(step) : lim;
            if (c > lim) begin
                if (sat_mode) begin c = lim; s = 1; end
                else          begin c = 0;   w = 1; end
            end else if (up_dn) begin
                if (c + es <= lim)  c = c + es;
                else if (sat_mode) begin c = lim; s = 1; end
                else               begin c = c + es - lim - 1; w = 1; end
            end else begin
                if (es <= c)        c = c - es;
                else if (sat_mode) begin c = 0; s = 1; end
                else               begin c = c + lim + 1 - es; w = 1; end
            end
        end
        m_count <= c;
        m_wrap  <= w;
        m_sat   <= s;
        if (rst) m_valid <= 1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (count !== 8'(m_count) || wrap_pulse !== m_wrap || sat_pulse !== m_sat ||
                at_zero !== (m_count == 0) || at_limit !== (m_count == int'(limit)) ||
                (wrap_pulse === 1'b1 && sat_pulse === 1'b1)) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual count=%0d wrap=%0b sat=%0b az=%0b al=%0b required count=%0d wrap=%0b sat=%0b az=%0b al=%0b",
                         $time, count, wrap_pulse, sat_pulse, at_zero, at_limit,
                         m_count, m_wrap, m_sat, (m_count == 0), (m_count == int'(limit)));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int c, input int w, input int s);
        check({name, "_count"}, int'(count), c);
        check({name, "_wrap"}, int'(wrap_pulse), w);
        check({name, "_sat"}, int'(sat_pulse), s);
    endtask

    task automatic cyc(input logic r, input logic l, input logic [7:0] d, input logic e,
                       input logic u, input logic [3:0] st, input logic [7:0] lm,
                       input logic s);
        rst      = r;
        load     = l;
        data_in  = d;
        enable   = e;
        up_dn    = u;
        step     = st;
        limit    = lm;
        sat_mode = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lim_r;
        lim_r = 200;

        // Reset and load with clamping
        cyc(1, 0, 8'h00, 0, 1, 4'd0, 8'hFF, 0);
        check_out("reset", 0, 0, 0);
        check("reset_at_zero", int'(at_zero), 1);
        cyc(0, 1, 8'hDE, 0, 1, 4'd0, 8'hFF, 0);
        check_out("load_de", 'hDE, 0, 0);
        cyc(0, 1, 8'hF0, 0, 1, 4'd0, 8'h80, 0);
        check_out("load_clamp", 'h80, 0, 0);
        check("load_clamp_at_limit", int'(at_limit), 1);

        // Up wrap: limit 9, step 3
        cyc(0, 1, 8'd0, 0, 1, 4'd3, 8'd9, 0);
        check_out("upw_start", 0, 0, 0);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0);
        check_out("upw_1", 3, 0, 0);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0);
        check_out("upw_2", 6, 0, 0);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0);
        check_out("upw_3", 9, 0, 0);
        check("upw_3_at_limit", int'(at_limit), 1);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0);
        check_out("upw_4", 2, 1, 0);

        // Down saturate: limit 200, step 15, from 20
        cyc(0, 1, 8'd20, 0, 0, 4'd15, 8'd200, 1);
        check_out("dns_load", 20, 0, 0);
        cyc(0, 0, 8'd0, 1, 0, 4'd15, 8'd200, 1);
        check_out("dns_1", 5, 0, 0);
        cyc(0, 0, 8'd0, 1, 0, 4'd15, 8'd200, 1);
        check_out("dns_2", 0, 0, 1);
        cyc(0, 0, 8'd0, 1, 0, 4'd15, 8'd200, 1);
        check_out("dns_3", 0, 0, 1);

        // Priority: rst over load/enable, load over enable, then hold
        cyc(1, 1, 8'h55, 1, 1, 4'd3, 8'd200, 0);
        check_out("prio_rst", RST_VAL, 0, 0);
        cyc(0, 1, 8'd7, 1, 1, 4'd3, 8'd200, 0);
        check_out("prio_load", 7, 0, 0);
        cyc(0, 0, 8'd0, 0, 1, 4'd3, 8'd200, 0);
        check_out("prio_hold", 7, 0, 0);

        // Runtime limit drop below the count
        cyc(0, 1, 8'd50, 0, 1, 4'd3, 8'd200, 0);
        check_out("drop_w_load", 50, 0, 0);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd20, 0);
        check_out("drop_wrap", 0, 1, 0);
        cyc(0, 1, 8'd50, 0, 1, 4'd3, 8'd200, 1);
        check_out("drop_s_load", 50, 0, 0);
        cyc(0, 0, 8'd0, 1, 0, 4'd3, 8'd20, 1);
        check_out("drop_sat", 20, 0, 1);
        check("drop_sat_at_limit", int'(at_limit), 1);

        // Limit 0 and step 0 leave the count alone
        cyc(0, 1, 8'd0, 0, 1, 4'd5, 8'd0, 0);
        cyc(0, 0, 8'd0, 1, 1, 4'd5, 8'd0, 0);
        check_out("lim0", 0, 0, 0);
        cyc(0, 1, 8'd33, 0, 1, 4'd0, 8'd100, 1);
        cyc(0, 0, 8'd0, 1, 0, 4'd0, 8'd100, 1);
        check_out("step0", 33, 0, 0);

        // Down wrap landing: limit 9, step 4 from 2 -> 2+10-4 = 8
        cyc(0, 1, 8'd2, 0, 0, 4'd4, 8'd9, 0);
        cyc(0, 0, 8'd0, 1, 0, 4'd4, 8'd9, 0);
        check_out("dnw", 8, 1, 0);

        // Randomised regression against the model
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: lim_r = int'($urandom_range(0, 15));
                1: lim_r = int'($urandom_range(0, 255));
                2: ;
                default: lim_r = 255;
            endcase
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 7) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                8'(lim_r),
                1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
